// File: rtl/keypad_pkg.sv
// Shared key codes, scan state encoding and raw-vector decode for the keypad scanner.
package keypad_pkg;

    localparam logic [3:0] KEY_0    = 4'd0;
    localparam logic [3:0] KEY_1    = 4'd1;
    localparam logic [3:0] KEY_2    = 4'd2;
    localparam logic [3:0] KEY_3    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_7    = 4'd7;
    localparam logic [3:0] KEY_8    = 4'd8;
    localparam logic [3:0] KEY_9    = 4'd9;
    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;
    localparam logic [3:0] KEY_NONE = 4'd15;

    typedef enum logic [1:0] {
        SCAN_COL0 = 2'd0,
        SCAN_COL1 = 2'd1,
        SCAN_COL2 = 2'd2
    } scan_state_t;

    // Raw vector bit index is row*3 + column.
    function automatic logic [3:0] pos_to_code(input logic [3:0] pos);
        logic [3:0] code;
        case (pos)
            4'd0:    code = KEY_1;
            4'd1:    code = KEY_2;
            4'd2:    code = KEY_3;
            4'd3:    code = KEY_4;
            4'd4:    code = KEY_5;
            4'd5:    code = KEY_6;
            4'd6:    code = KEY_7;
            4'd7:    code = KEY_8;
            4'd8:    code = KEY_9;
            4'd9:    code = KEY_STAR;
            4'd10:   code = KEY_0;
            4'd11:   code = KEY_HASH;
            default: code = KEY_NONE;
        endcase
        return code;
    endfunction

    // Exactly one pressed key yields its code; none or several (ghosting) yield KEY_NONE.
    function automatic logic [3:0] raw_to_code(input logic [11:0] raw);
        logic [3:0] code;
        logic [3:0] hits;
        code = KEY_NONE;
        hits = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (raw[i]) begin
                hits = hits + 4'd1;
                code = pos_to_code(4'(i));
            end
        end
        return (hits == 4'd1) ? code : KEY_NONE;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Per-scan debounce of the raw key code: a candidate must repeat for
// DEBOUNCE_SCANS scans before it becomes the accepted code.
module key_debouncer
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_done,
    input  logic [3:0] raw_code,
    output logic [3:0] accepted,
    output logic [3:0] accepted_next,
    output logic       strobe
);

    localparam int CW = (DEBOUNCE_SCANS > 2) ? $clog2(DEBOUNCE_SCANS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS - 1);

    logic [3:0]    candidate;
    logic [CW-1:0] stable_cnt;
    logic          accept;

    assign accept        = (stable_cnt == CNT_MAX) && (candidate != accepted);
    assign accepted_next = accept ? candidate : accepted;

    // Track the candidate across scans and latch it once it has been stable long enough.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            candidate  <= KEY_NONE;
            stable_cnt <= '0;
            accepted   <= KEY_NONE;
            strobe     <= 1'b0;
        end else begin
            accepted <= accepted_next;
            strobe   <= accept && (candidate != KEY_NONE);
            if (scan_done) begin
                if (raw_code == candidate) begin
                    if (stable_cnt != CNT_MAX)
                        stable_cnt <= stable_cnt + CW'(1);
                end else begin
                    candidate  <= raw_code;
                    stable_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner: column drive, row sampling, debounce and
// decoded level outputs for the digital lock.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] ROW,
    output logic [2:0] COL,
    output logic [9:0] KEY,
    output logic       STAR,
    output logic       HASH,
    output logic       KEY_VALID,
    output logic [3:0] KEY_CODE,
    output logic       KEY_STROBE
);

    localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] CNT_LAST = DW'(SCAN_DIV - 1);

    logic [3:0]    row_s1;
    logic [3:0]    row_s2;
    scan_state_t   state;
    logic [DW-1:0] col_cnt;
    logic [3:0]    samp0;
    logic [3:0]    samp1;
    logic [11:0]   raw_vec;
    logic [3:0]    raw_code;
    logic          scan_done;
    logic [3:0]    accepted;
    logic [3:0]    accepted_next;

    // Bring the asynchronous row lines into the clock domain.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            row_s1 <= 4'b1111;
            row_s2 <= 4'b1111;
        end else begin
            row_s1 <= ROW;
            row_s2 <= row_s1;
        end
    end

    // Column 2 sample is taken live on the final cycle of the scan.
    assign raw_vec = {~row_s2[3], samp1[3], samp0[3],
                      ~row_s2[2], samp1[2], samp0[2],
                      ~row_s2[1], samp1[1], samp0[1],
                      ~row_s2[0], samp1[0], samp0[0]};

    // Scan FSM: hold each column low for SCAN_DIV cycles, sample rows on the last one.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= SCAN_COL0;
            col_cnt   <= '0;
            COL       <= 3'b110;
            samp0     <= 4'b0000;
            samp1     <= 4'b0000;
            raw_code  <= KEY_NONE;
            scan_done <= 1'b0;
        end else begin
            scan_done <= 1'b0;
            if (col_cnt == CNT_LAST) begin
                col_cnt <= '0;
                case (state)
                    SCAN_COL0: begin
                        samp0 <= ~row_s2;
                        state <= SCAN_COL1;
                        COL   <= 3'b101;
                    end
                    SCAN_COL1: begin
                        samp1 <= ~row_s2;
                        state <= SCAN_COL2;
                        COL   <= 3'b011;
                    end
                    SCAN_COL2: begin
                        raw_code  <= raw_to_code(raw_vec);
                        scan_done <= 1'b1;
                        state     <= SCAN_COL0;
                        COL       <= 3'b110;
                    end
                    default: begin
                        state <= SCAN_COL0;
                        COL   <= 3'b110;
                    end
                endcase
            end else begin
                col_cnt <= col_cnt + DW'(1);
            end
        end
    end

    key_debouncer #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debouncer (
        .clk          (CLK),
        .rst          (RESET),
        .scan_done    (scan_done),
        .raw_code     (raw_code),
        .accepted     (accepted),
        .accepted_next(accepted_next),
        .strobe       (KEY_STROBE)
    );

    assign KEY_CODE = accepted;

    // Register the decoded levels from the next accepted code so they move with KEY_CODE.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            KEY       <= 10'b0;
            STAR      <= 1'b0;
            HASH      <= 1'b0;
            KEY_VALID <= 1'b0;
        end else begin
            KEY       <= (accepted_next <= KEY_9) ? (10'd1 << accepted_next) : 10'b0;
            STAR      <= (accepted_next == KEY_STAR);
            HASH      <= (accepted_next == KEY_HASH);
            KEY_VALID <= (accepted_next != KEY_NONE);
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3 (12-cycle scan).
module tb_keypad_scanner;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [3:0] ROW;
    logic [2:0] COL;
    logic [9:0] KEY;
    logic       STAR;
    logic       HASH;
    logic       KEY_VALID;
    logic [3:0] KEY_CODE;
    logic       KEY_STROBE;

    logic [11:0] pressed = 12'b0;
    logic [3:0]  sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_strobe = 0;

    keypad_scanner #(
        .SCAN_DIV(4),
        .DEBOUNCE_SCANS(3)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .ROW       (ROW),
        .COL       (COL),
        .KEY       (KEY),
        .STAR      (STAR),
        .HASH      (HASH),
        .KEY_VALID (KEY_VALID),
        .KEY_CODE  (KEY_CODE),
        .KEY_STROBE(KEY_STROBE)
    );

    always #5 CLK = ~CLK;

    // Keypad model: a held key at (r,c) pulls row r low while column c is driven low.
    always_comb begin
        ROW = 4'b1111;
        for (int r = 0; r < 4; r++)
            ROW[r] = ~|(pressed[r*3 +: 3] & ~COL);
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pos_of(input int code);
        if (code >= 1 && code <= 9) return code - 1;
        if (code == 10) return 9;
        if (code == 0) return 10;
        return 11;
    endfunction

    task automatic hold(input int code);
        pressed = 12'b0;
        pressed[pos_of(code)] = 1'b1;
    endtask

    task automatic release_all();
        pressed = 12'b0;
    endtask

    task automatic scans(input int n);
        repeat (n * 12) @(posedge CLK);
        @(negedge CLK);
    endtask

    // Monitor: per-cycle output consistency and strobe-vs-scoreboard check.
    always @(negedge CLK) begin
        if (!RESET) begin
            logic [9:0] exp_key;
            logic [3:0] exp_code;
            exp_key = (KEY_CODE <= 4'd9) ? (10'd1 << KEY_CODE) : 10'd0;
            check("key_vs_code", int'(KEY), int'(exp_key));
            check("star_vs_code", int'(STAR), int'(KEY_CODE == 4'd10));
            check("hash_vs_code", int'(HASH), int'(KEY_CODE == 4'd11));
            check("valid_vs_levels", int'(KEY_VALID), int'(|{KEY, STAR, HASH}));
            if (KEY_STROBE) begin
                n_strobe++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_strobe: code %0d, expected no strobe (t=%0t)", KEY_CODE, $time);
                end else begin
                    exp_code = sb.pop_front();
                    check("strobe_code", int'(KEY_CODE), int'(exp_code));
                end
            end
        end
    end

    initial begin
        logic [2:0] pat[3];
        int s0;
        pat[0] = 3'b110;
        pat[1] = 3'b101;
        pat[2] = 3'b011;

        // Reset values
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_col", int'(COL), 6);
        check("rst_key", int'(KEY), 0);
        check("rst_code", int'(KEY_CODE), 15);
        check("rst_valid", int'(KEY_VALID), 0);
        check("rst_strobe", int'(KEY_STROBE), 0);

        // Column sequencing with no key held
        RESET = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (i > 0) @(negedge CLK);
            check("col_seq", int'(COL), int'(pat[(i / 4) % 3]));
            check("col_onehot_low", $countones(~COL), 1);
        end

        // Clean press of '7' then release
        sb.push_back(4'd7);
        hold(7);
        scans(1);
        check("press7_not_early", int'(KEY_CODE), 15);
        scans(5);
        check("press7_key", int'(KEY), 10'b0010000000);
        check("press7_code", int'(KEY_CODE), 7);
        check("press7_valid", int'(KEY_VALID), 1);
        s0 = n_strobe;
        release_all();
        scans(6);
        check("rel7_code", int'(KEY_CODE), 15);
        check("rel7_key", int'(KEY), 0);
        check("rel7_no_strobe", n_strobe, s0);

        // Bounce on '3' every scan, then hold
        s0 = n_strobe;
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0) hold(3);
            else release_all();
            repeat (12) @(posedge CLK);
            @(negedge CLK);
            check("bounce_code", int'(KEY_CODE), 15);
        end
        check("bounce_no_strobe", n_strobe, s0);
        sb.push_back(4'd3);
        hold(3);
        scans(6);
        check("bounce_settle_code", int'(KEY_CODE), 3);
        check("bounce_one_strobe", n_strobe, s0 + 1);
        release_all();
        scans(6);

        // Reset mid-scan with '5' held
        sb.push_back(4'd5);
        hold(5);
        scans(6);
        check("hold5_code", int'(KEY_CODE), 5);
        @(posedge CLK);
        #3 RESET = 1'b1;
        #1;
        check("midrst_col", int'(COL), 6);
        check("midrst_key", int'(KEY), 0);
        check("midrst_code", int'(KEY_CODE), 15);
        check("midrst_strobe", int'(KEY_STROBE), 0);
        repeat (3) @(negedge CLK);
        s0 = n_strobe;
        sb.push_back(4'd5);
        RESET = 1'b0;
        scans(2);
        check("postrst_no_early", int'(KEY_CODE), 15);
        check("postrst_no_strobe", n_strobe, s0);
        scans(4);
        check("postrst_code", int'(KEY_CODE), 5);
        check("postrst_one_strobe", n_strobe, s0 + 1);
        release_all();
        scans(6);

        // Multi-key rejection
        sb.push_back(4'd1);
        hold(1);
        scans(6);
        check("multi_first_code", int'(KEY_CODE), 1);
        s0 = n_strobe;
        pressed[pos_of(9)] = 1'b1;
        scans(6);
        check("multi_both_code", int'(KEY_CODE), 15);
        check("multi_no_strobe", n_strobe, s0);
        sb.push_back(4'd1);
        pressed[pos_of(9)] = 1'b0;
        scans(6);
        check("multi_back_code", int'(KEY_CODE), 1);
        check("multi_back_strobe", n_strobe, s0 + 1);
        release_all();
        scans(6);
        check("multi_rel_code", int'(KEY_CODE), 15);

        // Star then direct change to hash
        sb.push_back(4'd10);
        hold(10);
        scans(6);
        check("star_level", int'(STAR), 1);
        check("star_key", int'(KEY), 0);
        check("star_code", int'(KEY_CODE), 10);
        s0 = n_strobe;
        sb.push_back(4'd11);
        hold(11);
        scans(6);
        check("hash_level", int'(HASH), 1);
        check("hash_star_off", int'(STAR), 0);
        check("hash_code", int'(KEY_CODE), 11);
        check("hash_strobe", n_strobe, s0 + 1);
        release_all();
        scans(6);
        check("final_code", int'(KEY_CODE), 15);
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
